// File: rtl/vectored_interrupt_controller.sv
// Vectored interrupt controller: edge/level capture, enable mask, lowest-index
// priority dispatch to one CPU with a request/acknowledge handshake.
//
// Ports:
//   clk          : clock, all state on the rising edge
//   reset_n      : synchronous active-low reset
//   interrupts   : raw requests, bit i is channel i+1
//   intDisabled  : CPU in handler; its rising use acknowledges a request
//   cfg_we       : configuration write strobe
//   cfg_addr     : 0=ENABLE 1=MODE 2=PENDING(W1C) 3=CURRENT(ro)
//   cfg_wdata    : configuration write data
//   cfg_rdata    : combinational read of the selected register
//   intCPU       : registered interrupt request to the CPU
//   intID        : registered ID (index+1) of the dispatched channel
module vectored_interrupt_controller #(
  parameter int NUM_INTERRUPTS = 16,
  parameter int ID_WIDTH       = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_INTERRUPTS-1:0] interrupts,
  input  logic                      intDisabled,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_addr,
  input  logic [NUM_INTERRUPTS-1:0] cfg_wdata,
  output logic [NUM_INTERRUPTS-1:0] cfg_rdata,
  output logic                      intCPU,
  output logic [ID_WIDTH-1:0]       intID
);

  localparam int N     = NUM_INTERRUPTS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int EXT_W = (N > ID_WIDTH) ? N : ID_WIDTH;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_MODE    = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_CURRENT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        enable_q, enable_d;
  logic [N-1:0]        mode_q, mode_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [N-1:0]        samp_q;
  logic                cpu_q, cpu_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  logic [N-1:0]        set_vec;
  logic [N-1:0]        elig;
  logic [N-1:0]        win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                any_elig;
  logic [N-1:0]        disp_clr;
  logic [N-1:0]        w1c;
  logic [EXT_W-1:0]    id_ext;

  // Level channels set every cycle they are high; edge channels only
  // when the previous-cycle sample was low. Reset clears the sample, so
  // a line held high through reset counts as a fresh edge.
  assign set_vec = interrupts & (mode_q | ~samp_q);

  assign elig     = pend_q & enable_q;
  assign any_elig = |elig;

  // Isolate the lowest set bit, then encode it.
  assign win_oh = elig & (~elig + N'(1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  assign w1c = (cfg_we && cfg_addr == A_PENDING) ? cfg_wdata : '0;

  always_comb begin
    state_d  = state_q;
    cpu_d    = cpu_q;
    id_d     = id_q;
    disp_clr = '0;
    unique case (state_q)
      S_IDLE: begin
        cpu_d = 1'b0;
        if (!intDisabled && any_elig) begin
          state_d  = S_REQ;
          cpu_d    = 1'b1;
          id_d     = ID_WIDTH'(win_idx) + ID_WIDTH'(1);
          disp_clr = win_oh;
        end
      end
      // Committed: config changes to the channel cannot withdraw it.
      S_REQ: begin
        cpu_d = 1'b1;
        if (intDisabled) begin
          state_d = S_SERVICE;
          cpu_d   = 1'b0;
        end
      end
      S_SERVICE: begin
        cpu_d = 1'b0;
        if (!intDisabled) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cpu_d   = 1'b0;
      end
    endcase
  end

  // New set wins over a same-cycle dispatch or W1C clear.
  assign pend_d = (pend_q & ~(disp_clr | w1c)) | set_vec;

  assign enable_d = (cfg_we && cfg_addr == A_ENABLE) ? cfg_wdata : enable_q;
  assign mode_d   = (cfg_we && cfg_addr == A_MODE)   ? cfg_wdata : mode_q;

  assign id_ext = EXT_W'(id_q);

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      A_ENABLE:  cfg_rdata = enable_q;
      A_MODE:    cfg_rdata = mode_q;
      A_PENDING: cfg_rdata = pend_q;
      A_CURRENT: cfg_rdata = id_ext[N-1:0];
      default:   cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      enable_q <= '1;
      mode_q   <= '0;
      pend_q   <= '0;
      samp_q   <= '0;
      cpu_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      samp_q   <= interrupts;
      cpu_q    <= cpu_d;
      id_q     <= id_d;
    end
  end

  assign intCPU = cpu_q;
  assign intID  = id_q;

endmodule

// File: doc/vectored_interrupt_controller.md
VECTORED_INTERRUPT_CONTROLLER -- requirements
Module: vectored_interrupt_controller

Interface
REQ-001 SHALL have parameter NUM_INTERRUPTS, default 16, legal range 1..32; number of interrupt channels.
REQ-002 SHALL have parameter ID_WIDTH, default 8; width of intID, with 2^ID_WIDTH > NUM_INTERRUPTS.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 interrupts  input  NUM_INTERRUPTS  raw requests; int1=bit0, int2=bit1, etc.
REQ-006 intDisabled  input  1  CPU in handler; its assertion is the acknowledge.
REQ-007 cfg_we  input  1  config write strobe.
REQ-008 cfg_addr  input  2  register select: 0=ENABLE, 1=MODE, 2=PENDING, 3=CURRENT.
REQ-009 cfg_wdata  input  NUM_INTERRUPTS  config write data.
REQ-010 cfg_rdata  output  NUM_INTERRUPTS  combinational read of the register selected by cfg_addr.
REQ-011 intCPU  output  1  registered interrupt request to the CPU.
REQ-012 intID  output  ID_WIDTH  registered ID of the dispatched channel (index+1).

Function
REQ-013 ENABLE (rw): a bit set makes that channel eligible for dispatch; masked channels still latch pending.
REQ-014 MODE (rw): bit=0 rising-edge mode, bit=1 level mode.
REQ-015 Edge mode: pending bit set on the cycle after interrupts[i]=1 with previous-cycle sample 0.
REQ-016 Level mode: pending bit set on every cycle after interrupts[i] is sampled 1.
REQ-017 PENDING (read / write-1-to-clear): cfg_we at addr 2 clears the bits that are 1 in cfg_wdata.
REQ-018 CURRENT (ro): intID zero-extended or truncated to NUM_INTERRUPTS; writes ignored.
REQ-019 Writes to ENABLE and MODE take effect the next cycle.
REQ-020 Eligible vector = PENDING & ENABLE; the lowest set index wins, via a parametrised priority encoder with no hand-written chain.
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE: if !intDisabled and eligible!=0, go to REQ next cycle, set intCPU=1, intID=winner+1, and clear the winner's pending bit.
REQ-023 REQ: hold intCPU=1 and intID; on intDisabled=1 go to SERVICE and clear intCPU next cycle.
REQ-024 SERVICE: intCPU=0, intID retained; on intDisabled=0 return to IDLE; a new dispatch can occur no earlier than the following cycle.
REQ-025 A dispatched request is committed: clearing ENABLE, MODE or PENDING of that channel while in REQ does not withdraw intCPU.
REQ-026 Latency: edge sampled at cycle k -> pending set at k+1 -> intCPU=1 at k+2 (IDLE, enabled, !intDisabled).
REQ-027 Simultaneous set and clear of one pending bit (new edge/level vs dispatch clear or W1C): set wins.
REQ-028 Level-mode source still high after dispatch re-pends on the next cycle and re-dispatches after SERVICE->IDLE.
REQ-029 Multiple edges on one channel before dispatch collapse into a single pending event.
REQ-030 intDisabled=1 while in IDLE blocks dispatch; pending bits keep accumulating.

Reset
REQ-031 reset_n=0 at a clock edge forces: state=IDLE, intCPU=0, intID=0, PENDING=0, ENABLE=all ones, MODE=0, edge-sample register=0.
REQ-032 Reset asserted mid-request (REQ or SERVICE) aborts it; pending events are lost.
REQ-033 An input held high through reset release in edge mode is seen as a rising edge on the first cycle after release.

Verification
REQ-034 Pulse bits 2 and 5 in the same cycle (all enabled, edge) -> intCPU=1, intID=3; ack/release -> intCPU=1, intID=6.
REQ-035 ENABLE=0xFFFE, pulse bit0 -> no intCPU, PENDING bit0=1; write ENABLE=0xFFFF -> intCPU=1, intID=1 two cycles later.
REQ-036 MODE bit4=1, hold interrupts[4] high across one handler -> intID=5 dispatched twice; PENDING[4] reads 1 while high.
REQ-037 Pending bit3, write PENDING with 0x0008 in the same cycle as a new edge on bit3 -> PENDING[3] stays 1.
REQ-038 Edge at cycle k -> intCPU=1 at k+2; intDisabled=1 at k+4 -> intCPU=0 at k+5; intDisabled held 1 blocks further dispatch.
REQ-039 reset_n=0 during REQ with two bits pending -> intCPU=0, intID=0, PENDING=0, ENABLE=all ones next cycle.
